// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame delimiters and the
// baud divider calculation used by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  // Frame delimiters recognised by the downstream control FSM.
  localparam logic [7:0] UART_SOF = 8'hFE;
  localparam logic [7:0] UART_EOF = 8'hEF;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int uart_tick_div(input int clk_freq, input int baud, input int oversample);
    return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle pulse every TICK_DIV clocks.
// Never re-phased; the receiver tolerates the resulting one-tick phase error.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int TICK_DIV = uart_tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CW       = $clog2(TICK_DIV + 1);

  logic [CW-1:0] div_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg <= '0;
      tick        <= 1'b0;
    end else if (div_cnt_reg == CW'(TICK_DIV - 1)) begin
      div_cnt_reg <= '0;
      tick        <= 1'b1;
    end else begin
      div_cnt_reg <= div_cnt_reg + CW'(1);
      tick        <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// Oversampling 8N1 UART receiver; good bytes appear on Rx_value with a one-cycle
// Rx_interrupt strobe. Define UART_RX_PARITY_EN for an even-parity bit and parity_error.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic       Rx_interrupt,
  output logic [7:0] Rx_value,
  output logic       framing_error,
`ifdef UART_RX_PARITY_EN
  output logic       parity_error,
`endif
  output logic       rx_busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]    B_LAST = 3'(UART_DATA_BITS - 1);

  logic           tick;
  logic           rx_meta_reg;
  logic           rx_s_reg;
  uart_rx_state_t state_reg;
  logic [SW-1:0]  s_cnt_reg;
  logic [2:0]     b_cnt_reg;
  logic [7:0]     shift_reg;
`ifdef UART_RX_PARITY_EN
  logic           parity_bit_reg;
`endif

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_reg   <= 1'b1;
      rx_s_reg      <= 1'b1;
      state_reg     <= IDLE;
      s_cnt_reg     <= '0;
      b_cnt_reg     <= '0;
      shift_reg     <= '0;
      Rx_value      <= 8'h00;
      Rx_interrupt  <= 1'b0;
      framing_error <= 1'b0;
      rx_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= 1'b0;
      parity_error   <= 1'b0;
`endif
    end else begin
      rx_meta_reg   <= rx_serial;
      rx_s_reg      <= rx_meta_reg;
      Rx_interrupt  <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
      if (tick) begin
        case (state_reg)
          IDLE: begin
            if (!rx_s_reg) begin
              state_reg <= START;
              s_cnt_reg <= '0;
              rx_busy   <= 1'b1;
            end
          end
          START: begin
            if (s_cnt_reg == S_MID) begin
              // Restarting the count here puts every later sample at mid-bit.
              s_cnt_reg <= '0;
              if (rx_s_reg) begin
                state_reg <= IDLE;
                rx_busy   <= 1'b0;
              end else begin
                state_reg <= DATA;
                b_cnt_reg <= '0;
              end
            end else begin
              s_cnt_reg <= s_cnt_reg + SW'(1);
            end
          end
          DATA: begin
            if (s_cnt_reg == S_LAST) begin
              s_cnt_reg            <= '0;
              shift_reg[b_cnt_reg] <= rx_s_reg;
              if (b_cnt_reg == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_reg <= PARITY;
`else
                state_reg <= STOP;
`endif
              end else begin
                b_cnt_reg <= b_cnt_reg + 3'd1;
              end
            end else begin
              s_cnt_reg <= s_cnt_reg + SW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (s_cnt_reg == S_LAST) begin
              s_cnt_reg      <= '0;
              parity_bit_reg <= rx_s_reg;
              state_reg      <= STOP;
            end else begin
              s_cnt_reg <= s_cnt_reg + SW'(1);
            end
          end
`endif
          STOP: begin
            if (s_cnt_reg == S_LAST) begin
              s_cnt_reg <= '0;
              if (rx_s_reg) begin
                state_reg <= IDLE;
                rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                if (parity_bit_reg != ^shift_reg) begin
                  parity_error <= 1'b1;
                end else begin
                  Rx_value     <= shift_reg;
                  Rx_interrupt <= 1'b1;
                end
`else
                Rx_value     <= shift_reg;
                Rx_interrupt <= 1'b1;
`endif
              end else begin
                framing_error <= 1'b1;
                state_reg     <= WAIT_HIGH;
              end
            end else begin
              s_cnt_reg <= s_cnt_reg + SW'(1);
            end
          end
          WAIT_HIGH: begin
            // A held-low line (break) must release before a new start can be seen.
            if (rx_s_reg) begin
              state_reg <= IDLE;
              rx_busy   <= 1'b0;
            end
          end
          default: begin
            state_reg <= IDLE;
            rx_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: drives serial frames at the true 115200 baud
// and checks strobes, values and latency as the receiver produces them.
module tb_uart_rx_byte;

  localparam int BIT_CLK  = 434;   // 50 MHz / 115200, rounded
  localparam int TICK_CLK = 27;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Half a start bit plus the remaining whole bits up to the stop mid-sample.
  localparam int LAT_NOM = (16 * (FRAME_BITS - 1) + 8) * TICK_CLK;
  localparam int LAT_LO  = LAT_NOM - TICK_CLK;
  localparam int LAT_HI  = LAT_NOM + TICK_CLK + 4;

  logic       clk;
  logic       reset;
  logic       rx_serial;
  logic       Rx_interrupt;
  logic [7:0] Rx_value;
  logic       framing_error;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int irq_seen = 0;
  int fe_seen = 0;
  int fe_exp = 0;
  int pe_seen = 0;
  int pe_exp = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_rx_byte dut (
    .clk          (clk),
    .reset        (reset),
    .rx_serial    (rx_serial),
    .Rx_interrupt (Rx_interrupt),
    .Rx_value     (Rx_value),
    .framing_error(framing_error),
`ifdef UART_RX_PARITY_EN
    .parity_error (parity_error),
`endif
    .rx_busy      (rx_busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, observed, expected);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_serial = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop_v, input logic bad_par);
    if (stop_v && !bad_par) begin
      exp_q.push_back(data);
      start_q.push_back(cyc);
    end
    if (!stop_v) fe_exp++;
    if (stop_v && bad_par) pe_exp++;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^data) ^ bad_par);
`endif
    drive_bit(stop_v);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, exp_q.size(), 0);
  endtask

  // Scoreboard: every strobe must match the oldest outstanding byte.
  initial begin
    int lat;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (Rx_interrupt || framing_error)
          check("irq_fe_exclusive", {31'd0, Rx_interrupt & framing_error}, 0);
        if (framing_error) fe_seen++;
`ifdef UART_RX_PARITY_EN
        if (parity_error) pe_seen++;
`endif
        if (Rx_interrupt) begin
          irq_seen++;
          check("irq_expected", {31'd0, exp_q.size() != 0}, 1);
          if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            lat  = cyc - start_q.pop_front();
            check("rx_value", Rx_value, want);
            check("latency_in_window", {31'd0, lat >= LAT_LO && lat <= LAT_HI}, 1);
            $display("rx byte %02h expected %02h latency %0d clk", Rx_value, want, lat);
          end
        end
      end
    end
  end

  initial begin
    #(200000 * 20);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b2b[4];
    logic [7:0] part;
    b2b[0] = 8'hFE; b2b[1] = 8'h03; b2b[2] = 8'h01; b2b[3] = 8'hEF;
    part = 8'h3C;

    rx_serial = 1'b1;
    reset     = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_irq", Rx_interrupt, 0);
    check("reset_value", Rx_value, 8'h00);
    check("reset_fe", framing_error, 0);
    check("reset_busy", rx_busy, 0);
    reset = 1'b0;

    repeat (2000) @(negedge clk);
    check("idle_no_irq", irq_seen, 0);
    check("idle_value", Rx_value, 8'h00);
    check("idle_busy", rx_busy, 0);

    send_byte(8'hFE, 1'b1, 1'b0);
    wait_drain("drain_fe");
    check("single_value", Rx_value, 8'hFE);
    check("single_count", irq_seen, 1);
    drive_bit(1'b1);

    for (int i = 0; i < 4; i++) send_byte(b2b[i], 1'b1, 1'b0);
    wait_drain("drain_b2b");
    check("b2b_count", irq_seen, 5);
    check("b2b_no_fe", fe_seen, 0);
    drive_bit(1'b1);

    // Short low pulse: start is seen, then rejected at mid-bit.
    rx_serial = 1'b0;
    repeat (100) @(negedge clk);
    check("glitch_busy_high", rx_busy, 1);
    repeat (30) @(negedge clk);
    rx_serial = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    check("glitch_busy_low", rx_busy, 0);
    check("glitch_no_irq", irq_seen, 5);

    send_byte(8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("fe_count", fe_seen, 1);
    check("fe_value_kept", Rx_value, 8'hEF);
    check("fe_busy_low", rx_busy, 0);
    send_byte(8'hA5, 1'b1, 1'b0);
    wait_drain("drain_a5");
    check("after_fe_value", Rx_value, 8'hA5);
    drive_bit(1'b1);

    // Abort 8'h3C with reset in the middle of bit 4.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(part[i]);
    rx_serial = part[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    reset = 1'b1;
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_value", Rx_value, 8'h00);
    check("midreset_busy", rx_busy, 0);
    check("midreset_irq", Rx_interrupt, 0);
    reset = 1'b0;
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("midreset_no_irq", irq_seen, 6);
    send_byte(8'h3C, 1'b1, 1'b0);
    wait_drain("drain_3c");
    check("after_reset_value", Rx_value, 8'h3C);
    drive_bit(1'b1);

`ifdef UART_RX_PARITY_EN
    send_byte(8'h07, 1'b1, 1'b1);
    drive_bit(1'b1);
    check("parity_count", pe_seen, pe_exp);
    check("parity_value_kept", Rx_value, 8'h3C);
`endif

    check("final_irq_count", irq_seen, 7);
    check("final_fe_count", fe_seen, fe_exp);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Serial UART receiver that sits directly upstream of the UART control FSM.
- Oversamples the asynchronous rx line, deframes 8N1 (8 data bits, no parity, 1 stop bit) characters, and presents each good byte on Rx_value with a one-cycle Rx_interrupt strobe.
- The control FSM consumes these strobes to parse frames of the form 0xFE, length, command, payload, 0xEF.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- OVERSAMPLE, 16, number of sample ticks per bit; must be even and at least 8.
- TICK_DIV, CLK_FREQ/(BAUD*OVERSAMPLE) rounded to nearest (27 at defaults), clocks per sample tick; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_serial  in  1  asynchronous UART line; idles high.
- Rx_interrupt  out  1  one-cycle strobe: a good byte is on Rx_value.
- Rx_value  out  8  last correctly received byte; held until the next good byte.
- framing_error  out  1  one-cycle strobe: stop bit sampled low.
- rx_busy  out  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset: sampled synchronously on the clk edge, overrides everything. Rx_interrupt=0, Rx_value=8'h00, framing_error=0, rx_busy=0. Synchronizer flops preset to 1, state=IDLE, all counters 0. Reset asserted mid-character aborts the character with no strobe.
- Input sync: two-flop synchronizer; all decisions use the second flop, rx_s.
- Tick generator: counter 0..TICK_DIV-1 produces a tick pulse on wrap. It runs freely; it does not re-phase on start detection. The resulting ±1-tick phase error is accepted.
- Sample counter: s_cnt 0..OVERSAMPLE-1, advanced only on ticks. Mid-bit is s_cnt==OVERSAMPLE/2-1.
- Bit counter: b_cnt 0..7.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 on a tick -> START with s_cnt=0; rx_busy goes 1.
  - START: at mid-bit, if rx_s==1 (glitch) -> IDLE, no strobe. Else s_cnt resets so later samples land mid-bit; -> DATA with b_cnt=0.
  - DATA: every OVERSAMPLE ticks, sample rx_s into shift register bit b_cnt (LSB first). After bit 7 -> STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - rx_s==1: Rx_value<=shift register, Rx_interrupt=1 for exactly the next clk cycle, -> IDLE.
    - rx_s==0: framing_error=1 for one cycle, Rx_value unchanged, -> WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1 on a tick (line break/hold-low), then -> IDLE.
- Latency: Rx_interrupt rises 1 clk after the mid-stop-bit sample tick, i.e. about 9.5 bit times after the falling start edge plus 2 sync cycles.
- Back-to-back characters: a start edge immediately after the stop mid-sample is detected, since the FSM is back in IDLE within the stop bit.
- Rx_interrupt and framing_error are never high in the same cycle. There is no consumer handshake; the downstream block must react to the strobe.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP that samples one even-parity bit.
  - Adds output port parity_error (1 bit, reset 0).
  - On mismatch at STOP with a good stop bit: parity_error=1 one cycle, no Rx_interrupt, Rx_value unchanged.
  - Framing error takes precedence over parity error; only framing_error pulses.
- Undefined: pure 8N1; no PARITY state and no parity_error port.

Decomposition:
- Shared package uart_pkg:
  - enum uart_rx_state_t {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH}.
  - Constant UART_DATA_BITS=8.
  - Frame byte constants UART_SOF=8'hFE and UART_EOF=8'hEF, also used by the control FSM.
- Sub-module: uart_baud_tick (parameters CLK_FREQ, BAUD, OVERSAMPLE; ports clk, reset, tick). Reusable by the transmitter.

Test Plan:
- Reset, then idle line high for 2000 clk -> no strobes, Rx_value=8'h00, rx_busy=0.
- Send 8'hFE at 115200 baud -> exactly one Rx_interrupt pulse, Rx_value=8'hFE, latency within ±1 tick of 9.5 bit times.
- Back-to-back 8'hFE, 8'h03, 8'h01, 8'hEF with no idle gap -> four pulses in order with matching values; no framing_error.
- 0.3-bit low glitch on idle line -> START aborts, no strobe, rx_busy returns to 0.
- 8'h55 with stop bit forced 0, then line held low 3 bit times -> one framing_error pulse, Rx_value keeps the previous byte; next 8'hA5 received correctly.
- Reset asserted during bit 4 of 8'h3C -> no strobe, outputs at reset values; the following 8'h3C received correctly. With UART_RX_PARITY_EN, send 8'h07 with odd parity bit -> parity_error pulse, no Rx_interrupt.
